// File: rtl/uart_tx16_if.sv
// uart_tx16_if: word handshake between the senone send stage (master) and the
// 16-bit UART transmitter (slave). Clock and reset are plain ports on the
// modules, not members of this interface.
interface uart_tx16_if;
   logic [15:0] tx_value;    // word to send, two's complement
   logic        start_tx;    // request to send tx_value
   logic        uart_ready;  // transmitter idle and able to take a word

   // Upstream stage: offers words and watches ready to pace its reads
   modport master (
      output tx_value,
      output start_tx,
      input  uart_ready
   );

   // Transmitter side
   modport slave (
      input  tx_value,
      input  start_tx,
      output uart_ready
   );
endinterface

// File: rtl/uart_tx16.sv
// uart_tx16: serialises one 16-bit word as two back-to-back UART frames
// (start, 8 data bits LSB first, stop) on a registered TX line.
// Optional even-parity bit per frame when the macro UART_TX16_PARITY_EN is
// defined; ports are identical in both builds.
module uart_tx16 #(
   parameter int CLKS_PER_BIT = 434,   // clock cycles per bit, 2..65535
   parameter bit MSB_FIRST    = 1'b1   // 1: high byte first, 0: low byte first
) (
   input  logic        clk,
   input  logic        reset,
   uart_tx16_if.slave  bus,
   output logic        tx,
   output logic        tx_busy,
   output logic [15:0] words_sent
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX16_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } state_t;
`endif

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic                byte_idx_q, byte_idx_d;
   // Low byte is the frame being shifted out; high byte holds the byte that
   // follows, so the whole accepted word lives in this one register.
   logic [15:0]         shift_q, shift_d;
   logic [15:0]         words_q, words_d;
   logic                tx_q, tx_d;
`ifdef UART_TX16_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic                baud_tick;

   assign baud_tick = (baud_q == BAUD_LAST);

   // State and datapath registers, including the registered TX line
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         byte_idx_q <= 1'b0;
         shift_q    <= '0;
         words_q    <= '0;
         tx_q       <= 1'b1;
`ifdef UART_TX16_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         words_q    <= words_d;
         tx_q       <= tx_d;
`ifdef UART_TX16_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // Next-state logic: bit timing, frame sequencing and word bookkeeping
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      words_d    = words_q;
`ifdef UART_TX16_PARITY_EN
      parity_d   = parity_q;
`endif

      if (state_q != ST_IDLE) begin
         baud_d = baud_tick ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // Ready is exactly "in IDLE", so start_tx here is an acceptance
            if (bus.start_tx) begin
               state_d    = ST_START;
               baud_d     = '0;
               bit_d      = '0;
               byte_idx_d = 1'b0;
               shift_d    = MSB_FIRST ? {bus.tx_value[7:0], bus.tx_value[15:8]}
                                      : bus.tx_value;
`ifdef UART_TX16_PARITY_EN
               parity_d   = 1'b0;
`endif
            end
         end

         ST_START: begin
            if (baud_tick) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               // Shift only the active byte; the queued byte stays put
               shift_d = {shift_q[15:8], 1'b0, shift_q[7:1]};
`ifdef UART_TX16_PARITY_EN
               parity_d = parity_q ^ shift_q[0];
`endif
               if (bit_q == 3'd7) begin
`ifdef UART_TX16_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

`ifdef UART_TX16_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (baud_tick) begin
               if (!byte_idx_q) begin
                  // Second frame follows the stop bit with no idle gap
                  shift_d    = {8'h00, shift_q[15:8]};
                  byte_idx_d = 1'b1;
                  state_d    = ST_START;
`ifdef UART_TX16_PARITY_EN
                  parity_d   = 1'b0;
`endif
               end else begin
                  words_d    = words_q + 16'd1;
                  byte_idx_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: TX level is decoded from the upcoming state so it can be
   // registered and still show the start bit on the cycle after acceptance
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX16_PARITY_EN
         ST_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = 1'b1;
      endcase
      bus.uart_ready = (state_q == ST_IDLE);
      tx_busy        = (state_q != ST_IDLE);
   end

   assign tx         = tx_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_uart_tx16.sv
// tb_uart_tx16: directed and random words through uart_tx16 at 4 clocks per
// bit, checked against a bit-level waveform model built from the frame rules.
module tb_uart_tx16;

   localparam int CPB = 4;
   localparam bit MSB = 1'b1;
`ifdef UART_TX16_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int WC = 2 * FRAME_BITS * CPB;   // cycles per word

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tx;
   logic        tx_busy;
   logic [15:0] words_sent;

   uart_tx16_if u_if ();

   uart_tx16 #(
      .CLKS_PER_BIT (CPB),
      .MSB_FIRST    (MSB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (u_if),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_words = '0;

   bit   exp_tx[$];
   bit   exp_rdy[$];
   logic obs_tx[$];
   logic obs_rdy[$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: one bit-time of a given level, ready low throughout
   function automatic void push_bit(input int level);
      for (int c = 0; c < CPB; c++) begin
         exp_tx.push_back(bit'(level));
         exp_rdy.push_back(1'b0);
      end
   endfunction

   // Model: whole word as two frames in the configured byte order
   function automatic void model_word(input logic [15:0] v);
      int w;
      int bytes [2];
      w = int'(v);
      bytes[0] = MSB ? (w / 256) : (w % 256);
      bytes[1] = MSB ? (w % 256) : (w / 256);
      for (int k = 0; k < 2; k++) begin
         push_bit(0);
         for (int i = 0; i < 8; i++) push_bit((bytes[k] >> i) & 1);
`ifdef UART_TX16_PARITY_EN
         push_bit($countones(bytes[k]) % 2);
`endif
         push_bit(1);
      end
   endfunction

   // Model: the single ready cycle between back-to-back words
   function automatic void model_gap();
      exp_tx.push_back(1'b1);
      exp_rdy.push_back(1'b1);
   endfunction

   function automatic void clear_all();
      exp_tx.delete();
      exp_rdy.delete();
      obs_tx.delete();
      obs_rdy.delete();
   endfunction

   task automatic check_status(input string tag, input logic rdy, input logic [15:0] words);
      chk(tag, {tx, u_if.uart_ready, tx_busy, words_sent}, {1'b1, rdy, ~rdy, words});
   endtask

   // Called just after a falling edge; returns just after the falling edge of
   // the first cycle following acceptance, with start_tx dropped.
   task automatic start_word(input logic [15:0] v);
      int w;
      w = 0;
      u_if.tx_value = v;
      u_if.start_tx = 1'b1;
      while (u_if.uart_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      checks++;
      assert (w < 200) else begin
         errors++;
         $error("FAIL ready_wait observed=busy expected=ready within 200 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      u_if.start_tx = 1'b0;
   endtask

   // Sample tx/ready for n cycles; optionally raise start_tx (with a value)
   // and drop it at given sample indices.
   task automatic capture(input int n, input int on_at, input logic [15:0] on_val, input int off_at);
      for (int i = 0; i < n; i++) begin
         obs_tx.push_back(tx);
         obs_rdy.push_back(u_if.uart_ready);
         if (i == on_at) begin
            u_if.tx_value = on_val;
            u_if.start_tx = 1'b1;
         end
         if (i == off_at) u_if.start_tx = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic cmp_waves(input string tag);
      logic [511:0] ot, et, orr, er;
      ot = '0; et = '0; orr = '0; er = '0;
      for (int i = 0; i < obs_tx.size(); i++) begin
         ot[i]  = obs_tx[i];
         orr[i] = obs_rdy[i];
      end
      for (int i = 0; i < exp_tx.size(); i++) begin
         et[i] = exp_tx[i];
         er[i] = exp_rdy[i];
      end
      chk({tag, "_tx"}, ot, et);
      chk({tag, "_ready"}, orr, er);
      chk({tag, "_len"}, 512'(obs_tx.size()), 512'(exp_tx.size()));
      $display("word %s: %0d cycles compared", tag, obs_tx.size());
   endtask

   task automatic send_single(input string tag, input logic [15:0] v);
      clear_all();
      model_word(v);
      start_word(v);
      capture(WC, -1, 16'h0000, -1);
      cmp_waves(tag);
      exp_words++;
      check_status({tag, "_end"}, 1'b1, exp_words);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] v;
      int gap;

      u_if.start_tx = 1'b0;
      u_if.tx_value = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 50; i++) begin
         check_status("idle", 1'b1, 16'h0000);
         @(negedge clk);
      end

      // Single pulse
      send_single("w12A5", 16'h12A5);

      // start_tx held: -2 then 1 on consecutive ready windows
      clear_all();
      model_word(16'hFFFE);
      model_gap();
      model_word(16'h0001);
      start_word(16'hFFFE);
      capture(2 * WC + 1, 0, 16'h0001, WC + 1);
      cmp_waves("b2b_FFFE_0001");
      exp_words += 16'd2;
      for (int i = 0; i < 6; i++) begin
         check_status("b2b_idle", 1'b1, exp_words);
         @(negedge clk);
      end

      // Request while busy is ignored
      v = 16'($urandom);
      clear_all();
      model_word(v);
      start_word(v);
      capture(WC, 10, 16'h5555, 11);
      cmp_waves("busy_ignore");
      exp_words++;
      for (int i = 0; i < 2 * WC; i++) begin
         check_status("busy_ignore_idle", 1'b1, exp_words);
         @(negedge clk);
      end

      // Reset during data bit 3 of the first byte
      v = 16'($urandom);
      clear_all();
      model_word(v);
      while (exp_tx.size() > 18) begin
         void'(exp_tx.pop_back());
         void'(exp_rdy.pop_back());
      end
      start_word(v);
      capture(18, -1, 16'h0000, -1);
      cmp_waves("pre_reset");
      reset = 1'b1;
      @(negedge clk);
      exp_words = '0;
      check_status("after_reset", 1'b1, exp_words);
      reset = 1'b0;
      @(negedge clk);
      check_status("after_reset2", 1'b1, exp_words);
      send_single("w00FF", 16'h00FF);

      // Parity-sensitive pattern (plain 8N1 in the default build)
      send_single("w0307", 16'h0307);

      // Random words with random idle gaps
      for (int k = 0; k < 8; k++) begin
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            check_status("rand_gap", 1'b1, exp_words);
            @(negedge clk);
         end
         send_single($sformatf("rand%0d", k), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
